// File: rtl/sram_ctrl_pkg.sv
// Shared types and default constants for the SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BASE_ADDR_DEF   = 1024;
  localparam int SRAM_AW_DEF     = 18;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int HALF_W          = 16;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/sram_ctrl_if.sv
// MEM-stage request/response bus between the pipeline and the SRAM controller.
interface sram_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output rd_en, wr_en, addr, wdata, input rdata, ready);
  modport slave  (input rd_en, wr_en, addr, wdata, output rdata, ready);
endinterface

// File: rtl/sram_wait_cnt.sv
// Wait-state counter shared by the low- and high-half SRAM accesses.
module sram_wait_cnt
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic term
);

  logic [CNT_W-1:0] cnt;

  // Count cycles spent in the current half; clear takes priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term = (cnt == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// 32-bit load/store responder performing two 16-bit asynchronous SRAM accesses.
// Optional one-entry read buffer: define SRAM_CTRL_RDBUF_EN.
//
// state | meaning
// IDLE  | waiting for a request; ready=1 when none is pending
// LO    | driving the low half-word access
// HI    | driving the high half-word access
// DONE  | access complete for one cycle, ready=1
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BASE_ADDR   = BASE_ADDR_DEF,
  parameter int SRAM_AW     = SRAM_AW_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_ctrl_if.slave         bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HALF_W-1:0]  sram_dq_o,
  input  logic [HALF_W-1:0]  sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  state_t             state_q, state_d;
  logic               is_wr;
  logic [SRAM_AW-2:0] word_q, word_in;
  logic [31:0]        wdata_q, rdata_q;
  logic               req, cnt_en, cnt_clr, term, buf_hit, hi_half;

  assign req     = bus.rd_en | bus.wr_en;
  assign word_in = (SRAM_AW-1)'((bus.addr - 32'(BASE_ADDR)) >> 2);
  assign cnt_clr = ~cnt_en | term;
  assign hi_half = (state_q == HI);

  assign bus.ready = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign bus.rdata = rdata_q;

  sram_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .term   (term)
  );

`ifdef SRAM_CTRL_RDBUF_EN
  logic               buf_valid;
  logic [SRAM_AW-2:0] buf_tag;
  logic [31:0]        buf_data;

  // A pure read of the buffered word skips the SRAM entirely.
  assign buf_hit = (state_q == IDLE) && bus.rd_en && !bus.wr_en &&
                   buf_valid && (buf_tag == word_in);

  // Fill on every completed read; keep coherent with writes to the same word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state_q == DONE) begin
      if (!is_wr) begin
        buf_valid <= 1'b1;
        buf_tag   <= word_q;
        buf_data  <= rdata_q;
      end else if (buf_valid && (buf_tag == word_q)) begin
        buf_data <= wdata_q;
      end
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  // State register plus latched request and read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      is_wr   <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && req) begin
        is_wr   <= bus.wr_en;
        word_q  <= word_in;
        wdata_q <= bus.wdata;
      end
      if (!is_wr && term) begin
        if (state_q == LO) rdata_q[15:0]  <= sram_dq_i;
        if (state_q == HI) rdata_q[31:16] <= sram_dq_i;
      end
`ifdef SRAM_CTRL_RDBUF_EN
      if (buf_hit) rdata_q <= buf_data;
`endif
    end
  end

  // Next-state logic and SRAM pin decode from the registered state.
  always_comb begin
    state_d    = state_q;
    cnt_en     = 1'b0;
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    case (state_q)
      IDLE: begin
        if (buf_hit)  state_d = DONE;
        else if (req) state_d = LO;
      end
      LO: begin
        cnt_en = 1'b1;
        if (term) state_d = HI;
      end
      HI: begin
        cnt_en = 1'b1;
        if (term) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cnt_en) begin
      sram_addr  = {word_q, hi_half};
      sram_dq_o  = hi_half ? wdata_q[31:16] : wdata_q[15:0];
      sram_dq_oe = is_wr;
      sram_we_n  = ~is_wr;
      sram_oe_n  = is_wr;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: vector table, reset corner cases, random traffic.
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int BASE = 1024;
  localparam int AW   = 18;
  localparam int W    = 2;
`ifdef SRAM_CTRL_RDBUF_EN
  localparam bit RDBUF = 1'b1;
`else
  localparam bit RDBUF = 1'b0;
`endif
  localparam int LAT_FULL = 2 * W + 1;
  localparam int LAT_HIT  = RDBUF ? 1 : LAT_FULL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if bus ();
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_we_n, sram_oe_n;

  sram_ctrl #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  // Asynchronous SRAM: reads are combinational; a write only lands once the
  // strobe has been held on one address for a full W-cycle pulse.
  logic [15:0]   sram_mem [0:(1<<AW)-1];
  logic [AW-1:0] pulse_addr = '0;
  int            pulse_len  = 0;
  assign sram_dq_i = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n) begin
      if (pulse_len != 0 && sram_addr == pulse_addr) begin
        pulse_len <= pulse_len + 1;
        if (pulse_len + 1 == W) sram_mem[sram_addr] <= sram_dq_o;
      end else begin
        pulse_addr <= sram_addr;
        pulse_len  <= 1;
        if (W == 1) sram_mem[sram_addr] <= sram_dq_o;
      end
    end else begin
      pulse_len <= 0;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: half-word memory, last load value, one-entry buffer tag.
  logic [15:0] ref_half [int];
  logic [31:0] last_rdata = 32'h0;
  bit          buf_valid  = 1'b0;
  int          buf_word   = 0;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return int'((off >> 2) & ((32'd1 << (AW - 1)) - 32'd1));
  endfunction

  function automatic logic [15:0] ref_rd(input int h);
    return ref_half.exists(h) ? ref_half[h] : 16'h0000;
  endfunction

  task automatic model(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] exp_rd, output int exp_lat, output bit hit);
    int wd;
    wd  = word_of(a);
    hit = RDBUF && rd && !wr && buf_valid && (buf_word == wd);
    exp_lat = hit ? 1 : LAT_FULL;
    if (wr) begin
      ref_half[2*wd]   = d[15:0];
      ref_half[2*wd+1] = d[31:16];
    end else begin
      last_rdata = {ref_rd(2*wd+1), ref_rd(2*wd)};
      buf_valid  = 1'b1;
      buf_word   = wd;
    end
    exp_rd = last_rdata;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   dq_o;
    logic          dq_oe;
    logic          we_n;
    logic          oe_n;
  } pin_t;
  pin_t trace[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Present one request, hold it until ready, record SRAM pins every cycle.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rdv);
    pin_t p;
    trace.delete();
    @(posedge clk); #1;
    bus.rd_en = rd; bus.wr_en = wr; bus.addr = a; bus.wdata = d;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      p.addr = sram_addr; p.dq_o = sram_dq_o; p.dq_oe = sram_dq_oe;
      p.we_n = sram_we_n; p.oe_n = sram_oe_n;
      trace.push_back(p);
      if (bus.ready) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    rdv = bus.rdata;
  endtask

  task automatic check_pins(input string name, input bit wr_op, input bit hit,
                            input logic [31:0] a, input logic [31:0] d);
    int bad;
    int wd;
    int half;
    pin_t e, b;
    bad = -1;
    wd  = word_of(a);
    for (int c = 0; c < trace.size(); c++) begin
      e.addr = '0; e.dq_o = trace[c].dq_o; e.dq_oe = 1'b0; e.we_n = 1'b1; e.oe_n = 1'b1;
      if (!hit && c >= 1 && c <= 2 * W) begin
        half   = (c - 1) / W;
        e.addr = AW'(2 * wd + half);
        e.dq_oe = wr_op; e.we_n = !wr_op; e.oe_n = wr_op;
        if (wr_op) e.dq_o = half ? d[31:16] : d[15:0];
      end
      if (bad < 0 && (trace[c].addr !== e.addr || trace[c].dq_o !== e.dq_o ||
                      trace[c].dq_oe !== e.dq_oe || trace[c].we_n !== e.we_n ||
                      trace[c].oe_n !== e.oe_n)) begin
        bad = c; b = e;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s pins cycle %0d: got addr=%0h dq_o=%0h dq_oe=%b we_n=%b oe_n=%b, want addr=%0h dq_o=%0h dq_oe=%b we_n=%b oe_n=%b",
               name, bad, trace[bad].addr, trace[bad].dq_o, trace[bad].dq_oe, trace[bad].we_n,
               trace[bad].oe_n, b.addr, b.dq_o, b.dq_oe, b.we_n, b.oe_n);
    end
  endtask

  task automatic do_check(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit use_tab, input logic [31:0] t_rd, input int t_lat,
                          input string name);
    logic [31:0] m_rd, got_rd, want_rd;
    int          m_lat, got_lat, want_lat;
    bit          hit;
    model(rd, wr, a, d, m_rd, m_lat, hit);
    want_rd  = use_tab ? t_rd  : m_rd;
    want_lat = use_tab ? t_lat : m_lat;
    txn(rd, wr, a, d, got_lat, got_rd);
    check({name, " latency"}, 32'(got_lat), 32'(want_lat));
    check({name, " rdata"}, got_rd, want_rd);
    check_pins(name, wr, hit, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd_addr;
    int          op;
    vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h00000000, LAT_FULL};
    vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hDEADBEEF, LAT_FULL};
    vecs[2] = '{1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 32'hDEADBEEF, LAT_FULL};
    vecs[3] = '{1'b1, 1'b0, 32'd1041, 32'h00000000, 32'hCAFEF00D, LAT_FULL};
    vecs[4] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hDEADBEEF, LAT_FULL};
    vecs[5] = '{1'b1, 1'b0, 32'd1035, 32'h00000000, 32'hDEADBEEF, LAT_HIT};
    vecs[6] = '{1'b0, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, LAT_FULL};
    vecs[7] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'h12345678, LAT_HIT};
    vecs[8] = '{1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 32'h12345678, LAT_FULL};
    vecs[9] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 32'hA5A55A5A, LAT_FULL};

    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;

    // Reset held with a pending store.
    rst = 1'b0;
    bus.rd_en = 1'b0; bus.wr_en = 1'b1; bus.addr = 32'd1032; bus.wdata = 32'hFFFF0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready with request", 32'(bus.ready), 32'd0);
    check("reset rdata", bus.rdata, 32'h0);
    check("reset pins", {sram_addr, sram_we_n, sram_oe_n, sram_dq_oe}, {18'h0, 3'b110});
    bus.wr_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("ready after release", 32'(bus.ready), 32'd1);

    for (int i = 0; i < 10; i++)
      do_check(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b1,
               vecs[i].exp_rdata, vecs[i].exp_lat, $sformatf("vec%0d", i));

    // Reset dropped during the high half of a store to word 6.
    idle(2);
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b1; bus.addr = 32'd1048; bus.wdata = 32'h11112222;
    repeat (3) @(posedge clk);
    #1;
    check("midrst in high half", {sram_addr, sram_we_n}, {18'd13, 1'b0});
    rst = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst pins idle", {sram_addr, sram_we_n, sram_oe_n, sram_dq_oe}, {18'h0, 3'b110});
    check("midrst rdata", bus.rdata, 32'h0);
    check("midrst ready", 32'(bus.ready), 32'd1);
    check("midrst low half written", 32'(sram_mem[12]), 32'h2222);
    check("midrst high half untouched", 32'(sram_mem[13]), 32'h0);
    rst = 1'b1;
    ref_half[12] = 16'h2222;
    last_rdata   = 32'h0;
    buf_valid    = 1'b0;
    do_check(1'b1, 1'b0, 32'd1048, 32'h0, 1'b0, 32'h0, 0, "read after midrst");

    // Random traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      op       = $urandom_range(0, 2);
      rnd_addr = 32'(BASE) + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      idle($urandom_range(0, 2));
      do_check(op != 1, op != 0, rnd_addr, $urandom, 1'b0, 32'h0, 0, $sformatf("rnd%0d", i));
    end
    idle(2);

    begin
      int bad_h;
      bad_h = -1;
      for (int h = 0; h < 16; h++)
        if (bad_h < 0 && sram_mem[h] !== ref_rd(h)) bad_h = h;
      checks++;
      if (bad_h >= 0) begin
        errors++;
        $display("FAIL sram contents half %0d: got %0h, want %0h", bad_h, sram_mem[bad_h], ref_rd(bad_h));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
